// File: rtl/b8b10enc.sv
// 8b/10b transmit encoder: valid/ready byte input, running-disparity tracking, K28.5 idle fill.
// Define OZ_SKP_INSERT_EN to force a K28.0 SKP symbol every SKP_INTERVAL emitted symbols.
module b8b10enc #(
  parameter logic [7:0]  IDLE_BYTE    = 8'hBC,
  parameter int unsigned SKP_INTERVAL = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_n,
  input  logic       enable_reverse,
  input  logic [7:0] txdata,
  input  logic       txdatak,
  input  logic       txvalid,
  output logic       txready,
  output logic [9:0] txout,
  output logic       txout_valid,
  output logic       txout_idle,
  output logic       rd_out,
  output logic       kerr
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;

  // 5b/6b codes (abcdei) as sent from RD-.
  function automatic logic [5:0] code6(input logic [4:0] x);
    case (x)
      5'd0:  code6 = 6'b100111;  5'd1:  code6 = 6'b011101;
      5'd2:  code6 = 6'b101101;  5'd3:  code6 = 6'b110001;
      5'd4:  code6 = 6'b110101;  5'd5:  code6 = 6'b101001;
      5'd6:  code6 = 6'b011001;  5'd7:  code6 = 6'b111000;
      5'd8:  code6 = 6'b111001;  5'd9:  code6 = 6'b100101;
      5'd10: code6 = 6'b010101;  5'd11: code6 = 6'b110100;
      5'd12: code6 = 6'b001101;  5'd13: code6 = 6'b101100;
      5'd14: code6 = 6'b011100;  5'd15: code6 = 6'b010111;
      5'd16: code6 = 6'b011011;  5'd17: code6 = 6'b100011;
      5'd18: code6 = 6'b010011;  5'd19: code6 = 6'b110010;
      5'd20: code6 = 6'b001011;  5'd21: code6 = 6'b101010;
      5'd22: code6 = 6'b011010;  5'd23: code6 = 6'b111010;
      5'd24: code6 = 6'b110011;  5'd25: code6 = 6'b100110;
      5'd26: code6 = 6'b010110;  5'd27: code6 = 6'b110110;
      5'd28: code6 = 6'b001110;  5'd29: code6 = 6'b101110;
      5'd30: code6 = 6'b011110;  default: code6 = 6'b101011;
    endcase
  endfunction

  // 3b/4b codes (fghj) as sent when the 6b sub-block leaves RD-; y=7 is P7.
  function automatic logic [3:0] code4(input logic [2:0] y);
    case (y)
      3'd0: code4 = 4'b1011;  3'd1: code4 = 4'b1001;
      3'd2: code4 = 4'b0101;  3'd3: code4 = 4'b1100;
      3'd4: code4 = 4'b1101;  3'd5: code4 = 4'b1010;
      3'd6: code4 = 4'b0110;  default: code4 = 4'b1110;
    endcase
  endfunction

  logic       skp_slot;
  logic [7:0] sel_byte, enc_byte;
  logic       sel_k, sel_idle, bad_k;
  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] c6_base, c6;
  logic [3:0] c4_base, c4;
  logic       unbal6, unbal4, rd6, flip4, rd_next;
  logic [9:0] sym, sym_rev;

`ifdef OZ_SKP_INSERT_EN
  logic [15:0] skp_cnt;

  assign skp_slot = (skp_cnt == 16'(SKP_INTERVAL - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  skp_cnt <= '0;
    else if (!en_n) skp_cnt <= skp_slot ? '0 : skp_cnt + 16'd1;
  end
`else
  assign skp_slot = 1'b0;
`endif

  assign txready = reset_n & ~en_n & ~skp_slot;

  // Pick what goes out this slot: SKP, accepted user data, or idle fill.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sel_byte = IDLE_BYTE;
    sel_k    = 1'b1;
    sel_idle = 1'b1;
    if (skp_slot) begin
      sel_byte = K28_0;
    end else if (txvalid && txready) begin
      sel_byte = txdata;
      sel_k    = txdatak;
      sel_idle = 1'b0;
    end
    bad_k = sel_k && !((sel_byte[4:0] == 5'd28) ||
            ((sel_byte[7:5] == 3'd7) && ((sel_byte[4:0] == 5'd23) || (sel_byte[4:0] == 5'd27) ||
                                         (sel_byte[4:0] == 5'd29) || (sel_byte[4:0] == 5'd30))));
    enc_byte = bad_k ? K28_5 : sel_byte;
    x = enc_byte[4:0];
    y = enc_byte[7:5];
  end

  always_comb begin
    c6_base = (sel_k && (x == 5'd28)) ? 6'b001111 : code6(x);
    unbal6  = ($countones(c6_base) != 3);
    // D.7 is balanced but still alternates with disparity.
    c6      = (rd_out && (unbal6 || (x == 5'd7))) ? ~c6_base : c6_base;
    rd6     = rd_out ^ unbal6;

    // A7 avoids a run of five equal bits across the e/i - f/g boundary.
    if ((y == 3'd7) && (sel_k || (!rd6 && (c6[1:0] == 2'b11)) || (rd6 && (c6[1:0] == 2'b00))))
      c4_base = 4'b0111;
    else
      c4_base = code4(y);
    unbal4 = ($countones(c4_base) != 2);
    // K28 balanced 4b codes take the opposite polarity from their data counterparts.
    if (sel_k && !unbal4 && (y != 3'd3)) flip4 = !rd6;
    else                                 flip4 = rd6 && (unbal4 || (y == 3'd3));
    c4      = flip4 ? ~c4_base : c4_base;
    rd_next = rd6 ^ unbal4;

    sym = {c6, c4};
    for (int i = 0; i < 10; i++) sym_rev[i] = sym[9-i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txout       <= '0;
      txout_valid <= 1'b0;
      txout_idle  <= 1'b0;
      rd_out      <= 1'b0;
      kerr        <= 1'b0;
    end else if (!en_n) begin
      // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
      txout       <= enable_reverse ? sym_rev : sym;
      txout_valid <= 1'b1;
      txout_idle  <= sel_idle;
      rd_out      <= rd_next;
      kerr        <= bad_k;
    end else begin
      txout_valid <= 1'b0;
      txout_idle  <= 1'b0;
      kerr        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_b8b10enc.sv
// Scoreboard bench for b8b10enc: an independent two-column 8b/10b table model predicts every symbol.
module tb_b8b10enc;
  localparam int         SKP  = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk = 1'b0;
  logic       reset_n, en_n, enable_reverse, txdatak, txvalid;
  logic [7:0] txdata;
  logic       txready, txout_valid, txout_idle, rd_out, kerr;
  logic [9:0] txout;

  always #5 clk = ~clk;

  b8b10enc #(.IDLE_BYTE(IDLE), .SKP_INTERVAL(SKP)) dut (
    .clk(clk), .reset_n(reset_n), .en_n(en_n), .enable_reverse(enable_reverse),
    .txdata(txdata), .txdatak(txdatak), .txvalid(txvalid), .txready(txready),
    .txout(txout), .txout_valid(txout_valid), .txout_idle(txout_idle),
    .rd_out(rd_out), .kerr(kerr)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0] sym;
    logic       idle;
    logic       kerr;
    logic       rd;
  } exp_t;

  exp_t       exp_q[$];
  logic       m_rd  = 1'b0;
  logic [9:0] m_sym = '0;
  int         m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {RD- column, RD+ column}
  function automatic logic [11:0] m6(input logic [4:0] x);
    case (x)
      5'd0:  m6 = {6'b100111, 6'b011000};  5'd1:  m6 = {6'b011101, 6'b100010};
      5'd2:  m6 = {6'b101101, 6'b010010};  5'd3:  m6 = {6'b110001, 6'b110001};
      5'd4:  m6 = {6'b110101, 6'b001010};  5'd5:  m6 = {6'b101001, 6'b101001};
      5'd6:  m6 = {6'b011001, 6'b011001};  5'd7:  m6 = {6'b111000, 6'b000111};
      5'd8:  m6 = {6'b111001, 6'b000110};  5'd9:  m6 = {6'b100101, 6'b100101};
      5'd10: m6 = {6'b010101, 6'b010101};  5'd11: m6 = {6'b110100, 6'b110100};
      5'd12: m6 = {6'b001101, 6'b001101};  5'd13: m6 = {6'b101100, 6'b101100};
      5'd14: m6 = {6'b011100, 6'b011100};  5'd15: m6 = {6'b010111, 6'b101000};
      5'd16: m6 = {6'b011011, 6'b100100};  5'd17: m6 = {6'b100011, 6'b100011};
      5'd18: m6 = {6'b010011, 6'b010011};  5'd19: m6 = {6'b110010, 6'b110010};
      5'd20: m6 = {6'b001011, 6'b001011};  5'd21: m6 = {6'b101010, 6'b101010};
      5'd22: m6 = {6'b011010, 6'b011010};  5'd23: m6 = {6'b111010, 6'b000101};
      5'd24: m6 = {6'b110011, 6'b001100};  5'd25: m6 = {6'b100110, 6'b100110};
      5'd26: m6 = {6'b010110, 6'b010110};  5'd27: m6 = {6'b110110, 6'b001001};
      5'd28: m6 = {6'b001110, 6'b001110};  5'd29: m6 = {6'b101110, 6'b010001};
      5'd30: m6 = {6'b011110, 6'b100001};  default: m6 = {6'b101011, 6'b010100};
    endcase
  endfunction

  // {code after 6b left RD-, code after 6b left RD+}
  function automatic logic [7:0] m4(input logic [2:0] y, input logic k);
    if (k) begin
      case (y)
        3'd0: m4 = {4'b1011, 4'b0100};  3'd1: m4 = {4'b0110, 4'b1001};
        3'd2: m4 = {4'b1010, 4'b0101};  3'd3: m4 = {4'b1100, 4'b0011};
        3'd4: m4 = {4'b1101, 4'b0010};  3'd5: m4 = {4'b0101, 4'b1010};
        3'd6: m4 = {4'b1001, 4'b0110};  default: m4 = {4'b0111, 4'b1000};
      endcase
    end else begin
      case (y)
        3'd0: m4 = {4'b1011, 4'b0100};  3'd1: m4 = {4'b1001, 4'b1001};
        3'd2: m4 = {4'b0101, 4'b0101};  3'd3: m4 = {4'b1100, 4'b0011};
        3'd4: m4 = {4'b1101, 4'b0010};  3'd5: m4 = {4'b1010, 4'b1010};
        3'd6: m4 = {4'b0110, 4'b0110};  default: m4 = {4'b1110, 4'b0001};
      endcase
    end
  endfunction

  task automatic m_encode(input logic [7:0] d, input logic k, output exp_t e);
    logic [4:0]  x;
    logic [2:0]  y;
    logic [11:0] p6;
    logic [7:0]  p4;
    logic [5:0]  c6;
    logic [3:0]  c4;
    logic        rd6, legal;
    x = d[4:0];
    y = d[7:5];
    legal = (x == 5'd28) || (y == 3'd7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
    e = '0;
    if (k && !legal) begin
      x = 5'd28;
      y = 3'd5;
      e.kerr = 1'b1;
    end
    p6  = (k && x == 5'd28) ? {6'b001111, 6'b110000} : m6(x);
    c6  = m_rd ? p6[5:0] : p6[11:6];
    rd6 = ($countones(c6) == 3) ? m_rd : !m_rd;
    if (!k && y == 3'd7 && ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                            (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
      p4 = {4'b0111, 4'b1000};
    else
      p4 = m4(y, k);
    c4    = rd6 ? p4[3:0] : p4[7:4];
    e.rd  = ($countones(c4) == 2) ? rd6 : !rd6;
    e.sym = {c6, c4};
  endtask

  // One symbol slot: drive, predict, then compare after the edge.
  task automatic step(input logic en, input logic v, input logic [7:0] d, input logic k,
                      input logic rev, output logic acc);
    exp_t       e;
    logic       rdy, skp;
    logic [9:0] r;
    en_n = !en; txvalid = v; txdata = d; txdatak = k; enable_reverse = rev;
`ifdef OZ_SKP_INSERT_EN
    skp = en && (m_cnt == SKP - 1);
`else
    skp = 1'b0;
`endif
    rdy = en && !skp;
    #1;
    check("txready", 32'(txready), 32'(rdy));
    acc = v && rdy;
    if (en) begin
      if (skp)      m_encode(8'h1C, 1'b1, e);
      else if (acc) m_encode(d, k, e);
      else          m_encode(IDLE, 1'b1, e);
      e.idle = !acc;
      m_rd = e.rd;
      if (rev) begin
        for (int i = 0; i < 10; i++) r[i] = e.sym[9-i];
        e.sym = r;
      end
      m_sym = e.sym;
      m_cnt = skp ? 0 : m_cnt + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (en) begin
      if (exp_q.size() == 0) begin
        check("queue_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("txout_valid", 32'(txout_valid), 32'd1);
        check("txout", 32'(txout), 32'(e.sym));
        check("txout_idle", 32'(txout_idle), 32'(e.idle));
        check("kerr", 32'(kerr), 32'(e.kerr));
        check("rd_out", 32'(rd_out), 32'(e.rd));
      end
    end else begin
      check("dis_valid", 32'(txout_valid), 32'd0);
      check("dis_idle", 32'(txout_idle), 32'd0);
      check("dis_kerr", 32'(kerr), 32'd0);
      check("dis_txout_hold", 32'(txout), 32'(m_sym));
      check("dis_rd_hold", 32'(rd_out), 32'(m_rd));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       acc;
    logic [7:0] legal_k[12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    int         sent, tries;

    reset_n = 1'b0; en_n = 1'b1; enable_reverse = 1'b0;
    txdata = '0; txdatak = 1'b0; txvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txout", 32'(txout), 32'd0);
    check("rst_valid", 32'(txout_valid), 32'd0);
    check("rst_idle", 32'(txout_idle), 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_kerr", 32'(kerr), 32'd0);
    en_n = 1'b0;
    #1;
    check("rst_txready", 32'(txready), 32'd0);
    reset_n = 1'b1;

`ifndef OZ_SKP_INSERT_EN
    // Idle alternation, then fixed reference symbols from RD-.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("gold_idle_rdm", 32'(txout), 32'(10'b0011111010));
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("gold_idle_rdp", 32'(txout), 32'(10'b1100000101));
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, acc);
    check("gold_d0_0", 32'(txout), 32'(10'b1001110100));
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, acc);
    check("gold_d0_0_rev", 32'(txout), 32'(10'b0010111001));
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, acc);
    check("gold_badk_sym", 32'(txout), 32'(10'b0011111010));
    check("gold_badk_kerr", 32'(kerr), 32'd1);
`endif
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    repeat (3) step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, acc);
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);

    // Randomised mix of data, legal/illegal K, reversal and disable gaps.
    for (int i = 0; i < 300; i++) begin
      logic       en, v, k, rev;
      logic [7:0] d;
      en  = ($urandom % 8) != 0;
      v   = ($urandom % 3) != 0;
      k   = ($urandom % 4) == 0;
      rev = ($urandom % 4) == 0;
      d   = 8'($urandom);
      if (k && ($urandom % 2 == 0)) d = legal_k[$urandom % 12];
      step(en, v, d, k, rev, acc);
    end

    // Mid-stream reset clears immediately and restarts from RD-.
    step(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, acc);
    reset_n = 1'b0;
    #1;
    check("mid_rst_txout", 32'(txout), 32'd0);
    check("mid_rst_valid", 32'(txout_valid), 32'd0);
    check("mid_rst_rd", 32'(rd_out), 32'd0);
    m_rd = 1'b0; m_sym = '0; m_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
`ifndef OZ_SKP_INSERT_EN
    check("gold_post_rst", 32'(txout), 32'(10'b0011111010));
`endif

    // Continuous source holding each byte until accepted.
    sent  = 0;
    tries = 0;
    while (sent < 24 && tries < 200) begin
      step(1'b1, 1'b1, 8'(sent * 37 + 3), 1'b0, 1'b0, acc);
      if (acc) sent++;
      tries++;
    end
    check("stream_sent", 32'(sent), 32'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
